opb_master_initiator: RTL and testbench
=======================================

OPB_MASTER_INITIATOR -- requirements
Module: opb_master_initiator

Interface
REQ-001 Parameters SHALL be: C_OPB_AWIDTH, 32, address width; C_OPB_DWIDTH, 32, data width; C_TOUT_CYCLES, 16, no-ack cycles before timeout; C_MAX_RETRY, 8, retries before error.
REQ-002 Clocking SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 OPB_Clk  in  1  sole clock; all logic rising-edge.
REQ-004 OPB_Rst_n  in  1  async active-low reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-006 cmd_rnw, cmd_addr, cmd_wdata, cmd_be  in  1, [31:0], [31:0], [3:0]  read=1, address, write data, byte enables.
REQ-007 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-008 rsp_data, rsp_status  out  [31:0], [1:0]  read data; 0=OK, 1=ERR, 2=TIMEOUT.
REQ-009 M_request, M_select, M_RNW, M_seqAddr, M_busLock  out  1 each  OPB master controls.
REQ-010 M_ABus, M_BE, M_DBus  out  [0:31], [0:3], [0:31]  address, byte enables, write data.
REQ-011 OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup  in  1 each  arbiter and slave responses.
REQ-012 OPB_DBus  in  [0:31]  read data.

Function
REQ-013 FSM SHALL have states IDLE, REQ, XFER, RESP.
REQ-014 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready the command SHALL be registered and the FSM SHALL enter REQ.
REQ-015 In REQ, M_request SHALL be 1; on sampling OPB_MGrant=1, the FSM SHALL enter XFER the next cycle.
REQ-016 In XFER, M_select SHALL be 1, M_request 0, and M_ABus/M_BE/M_RNW SHALL carry the registered command, MSB-to-MSB (M_ABus[0]=cmd_addr[31]).
REQ-017 M_DBus SHALL equal the write data only when M_select=1 and M_RNW=0, else all zeros; every M_* output SHALL be 0 outside XFER (OR-bus rule).
REQ-018 M_seqAddr and M_busLock SHALL be tied 0.
REQ-019 OPB_xferAck=1 in XFER SHALL capture OPB_DBus into rsp_data on reads (zero on writes), set status OK, deassert M_select next cycle, and enter RESP.
REQ-020 OPB_errAck with OPB_xferAck SHALL yield status ERR, with data still captured.
REQ-021 OPB_retry in XFER SHALL take precedence over xferAck/errAck: drop M_select, increment the retry counter, return to REQ; if the count reaches C_MAX_RETRY, enter RESP with ERR.
REQ-022 The timeout counter SHALL count XFER cycles without ack/retry, hold while OPB_toutSup=1, and on reaching C_TOUT_CYCLES enter RESP with TIMEOUT.
REQ-023 Both counters SHALL clear on command acceptance.
REQ-024 In RESP, rsp_valid SHALL be 1 with data/status stable until rsp_ready; then the FSM SHALL return to IDLE.
REQ-025 Minimum latency, grant on first REQ cycle and ack on first XFER cycle: accept at cycle 0, M_request at 1, M_select at 2, rsp_valid at 3.

Reset
REQ-026 On OPB_Rst_n=0, including mid-transaction, the FSM SHALL go to IDLE and all outputs and counters SHALL be 0 immediately; cmd_ready SHALL be 1 from the first clock after release.

Structure
REQ-027 The shared package SHALL hold the state enum, rsp_status encodings, and default C_TOUT_CYCLES / C_MAX_RETRY.
REQ-028 The timeout/retry counter pair SHALL be one sub-module, opb_xfer_watchdog.

Verification
REQ-029 Write 0x01000004 data 0xDEADBEEF BE=0xF, grant at once, ack in 1st XFER cycle -> M_DBus=0xDEADBEEF only while M_select=1; rsp_status=0 at cycle 3.
REQ-030 Read 0x01000000, slave returns 0x12345678 with xferAck after 3 wait cycles -> rsp_data=0x12345678, status OK, held until rsp_ready.
REQ-031 Retry asserted twice, then ack -> two REQ re-entries; status OK. Retry asserted 8 times -> status ERR.
REQ-032 No ack: with toutSup=0 -> TIMEOUT after 16 XFER cycles; with toutSup=1 for 10 of those cycles -> TIMEOUT after 26.
REQ-033 errAck+xferAck -> status ERR. Reset pulsed during XFER -> M_select=0 asynchronously, then cmd_ready=1 after release.

Source files
------------

// File: rtl/opb_master_initiator_pkg.sv
// rtl/opb_master_initiator_pkg.sv - shared state, response codes and default limits for the OPB master
package opb_master_initiator_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // rsp_status encodings
    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_ERR     = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;

    // Default watchdog limits
    localparam int DEF_TOUT_CYCLES = 16;
    localparam int DEF_MAX_RETRY   = 8;

endpackage

// File: rtl/opb_master_initiator_watchdog.sv
// rtl/opb_master_initiator_watchdog.sv - timeout and retry counter pair guarding one OPB data phase
module opb_xfer_watchdog
    import opb_master_initiator_pkg::*;
#(
    parameter int C_TOUT_CYCLES = DEF_TOUT_CYCLES,
    parameter int C_MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic xfer_active,
    input  logic xfer_ack,
    input  logic retry,
    input  logic tout_sup,
    output logic retry_hit,
    output logic tout_hit
);

    localparam int RW = $clog2(C_MAX_RETRY + 1);
    localparam int TW = $clog2(C_TOUT_CYCLES + 1);

    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] tout_cnt;
    logic          retry_evt;
    logic          tout_evt;

    // A retry wins over any ack; a timeout cycle is a data-phase cycle with neither and no suppression
    assign retry_evt = xfer_active & retry;
    assign tout_evt  = xfer_active & ~retry & ~xfer_ack & ~tout_sup;

    // Hits fire on the event that would bring the count to its limit
    assign retry_hit = retry_evt && (retry_cnt == RW'(C_MAX_RETRY - 1));
    assign tout_hit  = tout_evt && (tout_cnt == TW'(C_TOUT_CYCLES - 1));

    // Saturating counters, cleared when a new command is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
            tout_cnt  <= '0;
        end else if (clear) begin
            retry_cnt <= '0;
            tout_cnt  <= '0;
        end else begin
            if (retry_evt && (retry_cnt != RW'(C_MAX_RETRY))) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            if (tout_evt && (tout_cnt != TW'(C_TOUT_CYCLES))) begin
                tout_cnt <= tout_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/opb_master_initiator.sv
// rtl/opb_master_initiator.sv - OPB master turning command/response handshakes into single-beat OPB transfers
module opb_master_initiator
    import opb_master_initiator_pkg::*;
#(
    parameter int C_OPB_AWIDTH  = 32,
    parameter int C_OPB_DWIDTH  = 32,
    parameter int C_TOUT_CYCLES = DEF_TOUT_CYCLES,
    parameter int C_MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
    input  logic [C_OPB_DWIDTH-1:0]   cmd_wdata,
    input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_OPB_DWIDTH-1:0]   rsp_data,
    output logic [1:0]                rsp_status,
    output logic                      M_request,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic                      M_seqAddr,
    output logic                      M_busLock,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    input  logic                      OPB_MGrant,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_toutSup,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus
);

    localparam int BW = C_OPB_DWIDTH / 8;

    state_t                   state;
    logic                     rnw_q;
    logic [C_OPB_AWIDTH-1:0]  addr_q;
    logic [C_OPB_DWIDTH-1:0]  wdata_q;
    logic [BW-1:0]            be_q;
    logic                     cmd_accept;
    logic                     retry_hit;
    logic                     tout_hit;

    assign cmd_accept = cmd_valid & cmd_ready;

    // No sequential-address bursts and no bus locking
    assign M_seqAddr = 1'b0;
    assign M_busLock = 1'b0;

    opb_xfer_watchdog #(
        .C_TOUT_CYCLES (C_TOUT_CYCLES),
        .C_MAX_RETRY   (C_MAX_RETRY)
    ) u_watchdog (
        .clk         (OPB_Clk),
        .rst_n       (OPB_Rst_n),
        .clear       (cmd_accept),
        .xfer_active (state == ST_XFER),
        .xfer_ack    (OPB_xferAck),
        .retry       (OPB_retry),
        .tout_sup    (OPB_toutSup),
        .retry_hit   (retry_hit),
        .tout_hit    (tout_hit)
    );

    // Transaction FSM; every bus and handshake output is registered and driven only in its own state
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= RSP_OK;
            M_request  <= 1'b0;
            M_select   <= 1'b0;
            M_RNW      <= 1'b0;
            M_ABus     <= '0;
            M_BE       <= '0;
            M_DBus     <= '0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_accept) begin
                        rnw_q     <= cmd_rnw;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        be_q      <= cmd_be;
                        cmd_ready <= 1'b0;
                        M_request <= 1'b1;
                        state     <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (OPB_MGrant) begin
                        M_request <= 1'b0;
                        M_select  <= 1'b1;
                        M_RNW     <= rnw_q;
                        M_ABus    <= addr_q;
                        M_BE      <= be_q;
                        M_DBus    <= rnw_q ? '0 : wdata_q;
                        state     <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    // Any terminating event releases the bus on the next cycle
                    if (OPB_retry || OPB_xferAck || tout_hit) begin
                        M_select <= 1'b0;
                        M_RNW    <= 1'b0;
                        M_ABus   <= '0;
                        M_BE     <= '0;
                        M_DBus   <= '0;
                    end
                    if (OPB_retry) begin
                        if (retry_hit) begin
                            rsp_valid  <= 1'b1;
                            rsp_data   <= '0;
                            rsp_status <= RSP_ERR;
                            state      <= ST_RESP;
                        end else begin
                            M_request <= 1'b1;
                            state     <= ST_REQ;
                        end
                    end else if (OPB_xferAck) begin
                        rsp_valid  <= 1'b1;
                        rsp_data   <= rnw_q ? OPB_DBus : '0;
                        rsp_status <= OPB_errAck ? RSP_ERR : RSP_OK;
                        state      <= ST_RESP;
                    end else if (tout_hit) begin
                        rsp_valid  <= 1'b1;
                        rsp_data   <= '0;
                        rsp_status <= RSP_TIMEOUT;
                        state      <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opb_master_initiator.sv
// tb/tb_opb_master_initiator.sv - self-checking bench for opb_master_initiator
module tb_opb_master_initiator;

    localparam int TOUT      = 16;
    localparam int MAX_RETRY = 8;
    localparam int BUDGET    = 400;

    logic        OPB_Clk;
    logic        OPB_Rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rnw;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        M_request;
    logic        M_select;
    logic        M_RNW;
    logic        M_seqAddr;
    logic        M_busLock;
    logic [0:31] M_ABus;
    logic [0:3]  M_BE;
    logic [0:31] M_DBus;
    logic        OPB_MGrant;
    logic        OPB_xferAck;
    logic        OPB_errAck;
    logic        OPB_retry;
    logic        OPB_toutSup;
    logic [0:31] OPB_DBus;

    int n_vec = 0;
    int n_err = 0;

    opb_master_initiator dut (
        .OPB_Clk     (OPB_Clk),
        .OPB_Rst_n   (OPB_Rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rnw     (cmd_rnw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_be      (cmd_be),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .M_request   (M_request),
        .M_select    (M_select),
        .M_RNW       (M_RNW),
        .M_seqAddr   (M_seqAddr),
        .M_busLock   (M_busLock),
        .M_ABus      (M_ABus),
        .M_BE        (M_BE),
        .M_DBus      (M_DBus),
        .OPB_MGrant  (OPB_MGrant),
        .OPB_xferAck (OPB_xferAck),
        .OPB_errAck  (OPB_errAck),
        .OPB_retry   (OPB_retry),
        .OPB_toutSup (OPB_toutSup),
        .OPB_DBus    (OPB_DBus)
    );

    initial OPB_Clk = 1'b0;
    always #5 OPB_Clk = ~OPB_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        OPB_MGrant  = 1'b0;
        OPB_xferAck = 1'b0;
        OPB_errAck  = 1'b0;
        OPB_retry   = 1'b0;
        OPB_toutSup = 1'b0;
        OPB_DBus    = '0;
    endtask

    // OR-bus rule: master drives its command only while selected, zeros otherwise
    task automatic bus_check(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be);
        logic [31:0] e_abus;
        logic [31:0] e_dbus;
        e_abus = M_select ? addr : 32'h0;
        e_dbus = (M_select && !rnw) ? wdata : 32'h0;
        check("m_abus", M_ABus, e_abus);
        check("m_dbus", M_DBus, e_dbus);
        check("m_be", {28'h0, M_BE}, M_select ? {28'h0, be} : 32'h0);
        check("m_rnw", {31'h0, M_RNW}, M_select ? {31'h0, rnw} : 32'h0);
        check("req_sel_excl", {31'h0, M_request & M_select}, 32'h0);
        check("seq_lock", {30'h0, M_seqAddr, M_busLock}, 32'h0);
        if (M_select) check("abus_msb", {31'h0, M_ABus[0]}, {31'h0, addr[31]});
    endtask

    // One command: slave retries n_retry data phases, then stalls wait_cyc cycles
    // (the first sup_cyc of them with toutSup) before acking; grant comes after gnt_dly request cycles
    task automatic run_txn(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] rdata, input int n_retry,
                           input int wait_cyc, input int sup_cyc, input logic err,
                           input int gnt_dly, input int rdy_dly);
        int          exp_cyc;
        int          exp_req;
        int          fin;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
        int          cyc;
        int          phase;
        int          rcnt;
        int          xcnt;
        int          req_entries;
        logic        prev_req;
        logic        prev_sel;
        logic        done;

        // Reference model: outcome and response cycle derived from the slave behaviour
        if (n_retry >= MAX_RETRY) begin
            exp_status = 2'd1;
            exp_data   = 32'h0;
            exp_req    = MAX_RETRY;
            exp_cyc    = MAX_RETRY * (gnt_dly + 2) + 1;
        end else begin
            exp_req = n_retry + 1;
            if (wait_cyc - sup_cyc >= TOUT) begin
                exp_status = 2'd2;
                exp_data   = 32'h0;
                fin        = sup_cyc + TOUT;
            end else begin
                exp_status = err ? 2'd1 : 2'd0;
                exp_data   = rnw ? rdata : 32'h0;
                fin        = wait_cyc + 1;
            end
            exp_cyc = n_retry * (gnt_dly + 2) + (gnt_dly + 1) + fin + 1;
        end

        check("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        @(posedge OPB_Clk); #1;
        cmd_valid   = 1'b0;
        cyc         = 1;
        phase       = 0;
        rcnt        = 0;
        xcnt        = 0;
        req_entries = 0;
        prev_req    = 1'b0;
        prev_sel    = 1'b0;
        done        = 1'b0;

        while (!done && cyc < BUDGET) begin
            bus_check(rnw, addr, wdata, be);
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                slave_idle();
                if (M_request && !prev_req) req_entries++;
                if (!M_select && prev_sel) phase++;
                if (M_select && !prev_sel) xcnt = 0;
                if (M_request) begin
                    if (rcnt >= gnt_dly) OPB_MGrant = 1'b1;
                    rcnt++;
                end else begin
                    rcnt = 0;
                end
                if (M_select) begin
                    if (phase < n_retry) begin
                        OPB_retry   = 1'b1;
                        OPB_xferAck = 1'b1;
                        OPB_errAck  = 1'($urandom_range(0, 1));
                        OPB_DBus    = $urandom;
                    end else if (xcnt < wait_cyc) begin
                        OPB_toutSup = (xcnt < sup_cyc);
                    end else begin
                        OPB_xferAck = 1'b1;
                        OPB_errAck  = err;
                        OPB_DBus    = rdata;
                    end
                    xcnt++;
                end
                prev_req = M_request;
                prev_sel = M_select;
                @(posedge OPB_Clk); #1;
                cyc++;
            end
        end
        slave_idle();

        if (!done) begin
            check("rsp_valid_budget", {31'h0, rsp_valid}, 32'h1);
        end else begin
            check("rsp_cycle", cyc, exp_cyc);
            check("rsp_status", {30'h0, rsp_status}, {30'h0, exp_status});
            check("rsp_data", rsp_data, exp_data);
            check("req_entries", req_entries, exp_req);
            check("cmd_ready_busy", {31'h0, cmd_ready}, 32'h0);
            for (int i = 0; i < rdy_dly; i++) begin
                @(posedge OPB_Clk); #1;
                check("rsp_hold_valid", {31'h0, rsp_valid}, 32'h1);
                check("rsp_hold_status", {30'h0, rsp_status}, {30'h0, exp_status});
                check("rsp_hold_data", rsp_data, exp_data);
                bus_check(rnw, addr, wdata, be);
            end
            rsp_ready = 1'b1;
            @(posedge OPB_Clk); #1;
            rsp_ready = 1'b0;
            check("rsp_drop", {31'h0, rsp_valid}, 32'h0);
            check("cmd_ready_back", {31'h0, cmd_ready}, 32'h1);
        end
    endtask

    initial begin
        int xc;
        int nr;
        int wc;
        int sc;
        int sel;
        OPB_Rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_rnw   = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_be    = '0;
        rsp_ready = 1'b0;
        slave_idle();

        // Reset state
        #23;
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_m_request", {31'h0, M_request}, 32'h0);
        check("rst_m_select", {31'h0, M_select}, 32'h0);
        check("rst_rsp", {rsp_data[29:0], rsp_status}, 32'h0);
        @(negedge OPB_Clk);
        OPB_Rst_n = 1'b1;
        @(posedge OPB_Clk); #1;
        check("rel_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // Minimum-latency write
        run_txn(1'b0, 32'h0100_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 0, 1'b0, 0, 0);
        // Read with 3 wait states, response held 3 cycles
        run_txn(1'b1, 32'h0100_0000, 32'h0, 4'hF, 32'h1234_5678, 0, 3, 0, 1'b0, 0, 3);
        // Two retries then ack; eight retries -> ERR
        run_txn(1'b1, 32'h0000_0040, 32'h0, 4'h3, 32'hCAFE_F00D, 2, 0, 0, 1'b0, 1, 0);
        run_txn(1'b0, 32'h8000_0010, 32'h5555_AAAA, 4'hC, 32'h0, 8, 0, 0, 1'b0, 0, 1);
        // No ack: timeout after 16, and after 26 with 10 suppressed cycles
        run_txn(1'b1, 32'h0000_1000, 32'h0, 4'hF, 32'h0, 0, 40, 0, 1'b0, 0, 0);
        run_txn(1'b0, 32'h0000_2000, 32'h0BAD_CAFE, 4'hF, 32'h0, 0, 40, 10, 1'b0, 0, 0);
        // errAck with xferAck on a read
        run_txn(1'b1, 32'hF000_0008, 32'h0, 4'h1, 32'h8765_4321, 0, 1, 0, 1'b1, 2, 0);

        // Reset pulsed mid-XFER
        cmd_valid = 1'b1;
        cmd_rnw   = 1'b1;
        cmd_addr  = 32'h0000_3000;
        cmd_be    = 4'hF;
        @(posedge OPB_Clk); #1;
        cmd_valid = 1'b0;
        xc = 0;
        for (int i = 0; i < 40 && xc < 8; i++) begin
            slave_idle();
            if (M_request) OPB_MGrant = 1'b1;
            if (M_select) xc++;
            @(posedge OPB_Clk); #1;
        end
        check("pre_rst_select", {31'h0, M_select}, 32'h1);
        #2;
        OPB_Rst_n = 1'b0;
        #1;
        check("async_rst_select", {31'h0, M_select}, 32'h0);
        check("async_rst_abus", M_ABus, 32'h0);
        check("async_rst_ready", {31'h0, cmd_ready}, 32'h0);
        slave_idle();
        @(negedge OPB_Clk);
        OPB_Rst_n = 1'b1;
        @(posedge OPB_Clk); #1;
        check("post_rst_ready", {31'h0, cmd_ready}, 32'h1);
        // Watchdog must restart from zero after the reset
        run_txn(1'b1, 32'h0000_3004, 32'h0, 4'hF, 32'h0, 0, 40, 0, 1'b0, 0, 0);

        // Randomized commands against the reference model
        for (int t = 0; t < 30; t++) begin
            sel = int'($urandom_range(0, 9));
            nr  = (sel == 0) ? int'($urandom_range(8, 9)) : (sel < 4 ? int'($urandom_range(1, 3)) : 0);
            wc  = (sel == 9) ? int'($urandom_range(16, 30)) : int'($urandom_range(0, 6));
            sc  = int'($urandom_range(0, (wc > 12) ? 12 : wc));
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
                    nr, wc, sc, 1'($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
